best_neighbor_select: RTL and testbench

Parametrised neighbor-table scanner for the RL routing datapath. On start it walks the node's neighbor table in the shared memory, writes the bestNeighbors list (Q >= mybestQ) and the closeNeighbors list (hops <= mybestH) with their counts, and selects the next hop on the fly. It sits after the mybestQ/mybestH computation and before the winner-policy stage, sharing the single memory port.

---
 rtl/best_neighbor_select_pkg.sv | 33 +++
 rtl/best_neighbor_select_if.sv | 16 +
 rtl/best_neighbor_select_nbr_tracker.sv | 48 ++++
 rtl/best_neighbor_select.sv | 232 +++++++++++++++++++++++
 tb/tb_best_neighbor_select.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/best_neighbor_select_pkg.sv
// Shared definitions for the neighbor-table scanner: state encoding,
// route class codes and the default memory map (also used by winner-policy).
package best_neighbor_select_pkg;

  localparam int BNS_WORD_WIDTH    = 16;
  localparam int BNS_ADDR_WIDTH    = 11;
  localparam int BNS_MAX_NEIGHBORS = 8;
  localparam int BNS_ADDR_STRIDE   = 2;

  localparam logic [10:0] BNS_NCOUNT_ADDR = 11'h2C4;
  localparam logic [10:0] BNS_NID_BASE    = 11'h072;
  localparam logic [10:0] BNS_NHOPS_BASE  = 11'h132;
  localparam logic [10:0] BNS_NQ_BASE     = 11'h172;
  localparam logic [10:0] BNS_BEST_BASE   = 11'h2F8;
  localparam logic [10:0] BNS_BESTH_BASE  = 11'h308;
  localparam logic [10:0] BNS_CLOSE_BASE  = 11'h318;
  localparam logic [10:0] BNS_CLOSEH_BASE = 11'h328;
  localparam logic [10:0] BNS_BCOUNT_ADDR = 11'h2B8;
  localparam logic [10:0] BNS_CCOUNT_ADDR = 11'h338;

  localparam logic [1:0] RC_NONE     = 2'd0;
  localparam logic [1:0] RC_BEST     = 2'd1;
  localparam logic [1:0] RC_CLOSE    = 2'd2;
  localparam logic [1:0] RC_FALLBACK = 2'd3;

  typedef enum logic [4:0] {
    S_IDLE, S_ARMED, S_CNT_W, S_CNT_C,
    S_ID_I, S_ID_C, S_HOP_I, S_HOP_C, S_Q_I, S_Q_C,
    S_EVAL, S_WB_ID, S_WB_H, S_WC_ID, S_WC_H, S_NEXT,
    S_WR_BC, S_WR_CC, S_DONE
  } bns_state_t;

endpackage

// File: rtl/best_neighbor_select_if.sv
// Single shared memory port: registered address/write strobe/write data
// from the scanner, read data returned one cycle after the address.
interface best_neighbor_select_if
  import best_neighbor_select_pkg::*;
#(
  parameter int WORD_WIDTH = BNS_WORD_WIDTH,
  parameter int ADDR_WIDTH = BNS_ADDR_WIDTH
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (output wr_en, output address, output data_out, input data_in);
  modport slave  (input wr_en, input address, input data_out, output data_in);
endinterface

// File: rtl/best_neighbor_select_nbr_tracker.sv
// Holds the best (id, hops, q) seen so far. A candidate wins on fewer hops,
// or equal hops and higher Q; full ties keep the earlier (already held) entry.
module best_neighbor_select_nbr_tracker
  import best_neighbor_select_pkg::*;
#(
  parameter int WORD_WIDTH = BNS_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  upd,
  input  logic [WORD_WIDTH-1:0] cand_id,
  input  logic [WORD_WIDTH-1:0] cand_hops,
  input  logic [WORD_WIDTH-1:0] cand_q,
  output logic [WORD_WIDTH-1:0] id,
  output logic [WORD_WIDTH-1:0] hops,
  output logic [WORD_WIDTH-1:0] q
);
  logic held;
  logic take;

  // Replace decision: empty tracker always takes the first candidate.
  always_comb begin
    take = 1'b0;
    if (upd)
      take = !held || (cand_hops < hops) || ((cand_hops == hops) && (cand_q > q));
  end

  // Tracked entry register, cleared at the start of each arm.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      held <= 1'b0;
      id   <= '0;
      hops <= '0;
      q    <= '0;
    end else if (clr) begin
      held <= 1'b0;
      id   <= '0;
      hops <= '0;
      q    <= '0;
    end else if (take) begin
      held <= 1'b1;
      id   <= cand_id;
      hops <= cand_hops;
      q    <= cand_q;
    end
  end
endmodule

// File: rtl/best_neighbor_select.sv
// Neighbor-table scanner: reads each entry, builds the bestNeighbors and
// closeNeighbors lists in shared memory and picks the next hop on the fly.
module best_neighbor_select
  import best_neighbor_select_pkg::*;
#(
  parameter int WORD_WIDTH    = BNS_WORD_WIDTH,
  parameter int ADDR_WIDTH    = BNS_ADDR_WIDTH,
  parameter int MAX_NEIGHBORS = BNS_MAX_NEIGHBORS,
  parameter int ADDR_STRIDE   = BNS_ADDR_STRIDE,
  parameter logic [ADDR_WIDTH-1:0] NCOUNT_ADDR = ADDR_WIDTH'(BNS_NCOUNT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] NID_BASE    = ADDR_WIDTH'(BNS_NID_BASE),
  parameter logic [ADDR_WIDTH-1:0] NHOPS_BASE  = ADDR_WIDTH'(BNS_NHOPS_BASE),
  parameter logic [ADDR_WIDTH-1:0] NQ_BASE     = ADDR_WIDTH'(BNS_NQ_BASE),
  parameter logic [ADDR_WIDTH-1:0] BEST_BASE   = ADDR_WIDTH'(BNS_BEST_BASE),
  parameter logic [ADDR_WIDTH-1:0] BESTH_BASE  = ADDR_WIDTH'(BNS_BESTH_BASE),
  parameter logic [ADDR_WIDTH-1:0] CLOSE_BASE  = ADDR_WIDTH'(BNS_CLOSE_BASE),
  parameter logic [ADDR_WIDTH-1:0] CLOSEH_BASE = ADDR_WIDTH'(BNS_CLOSEH_BASE),
  parameter logic [ADDR_WIDTH-1:0] BCOUNT_ADDR = ADDR_WIDTH'(BNS_BCOUNT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] CCOUNT_ADDR = ADDR_WIDTH'(BNS_CCOUNT_ADDR)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] mybestQ,
  input  logic [WORD_WIDTH-1:0] mybestH,
  best_neighbor_select_if.master bus,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] bestQValue,
  output logic [WORD_WIDTH-1:0] best_count,
  output logic [WORD_WIDTH-1:0] close_count,
  output logic [1:0]            route_class,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);
  bns_state_t            state;
  logic [WORD_WIDTH-1:0] eff_cnt, n_idx, n_next;
  logic [WORD_WIDTH-1:0] cur_id, cur_hops, cur_q;
  logic                  close_flag, is_best, is_close, trk_clr, upd_best, upd_all;
  logic [WORD_WIDTH-1:0] bt_id, bt_hops, bt_q, at_id, at_hops, at_q;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] base,
                                                    input logic [WORD_WIDTH-1:0] idx);
    return base + ADDR_WIDTH'(ADDR_STRIDE) * idx[ADDR_WIDTH-1:0];
  endfunction

  // Threshold tests on the captured entry and tracker strobes.
  always_comb begin
    is_best  = cur_q >= mybestQ;
    is_close = cur_hops <= mybestH;
    n_next   = n_idx + WORD_WIDTH'(1);
    trk_clr  = (state == S_IDLE) && en;
    upd_all  = (state == S_EVAL);
    upd_best = (state == S_EVAL) && is_best;
  end

  best_neighbor_select_nbr_tracker #(.WORD_WIDTH(WORD_WIDTH)) u_best_trk (
    .clock(clock), .rst(rst), .clr(trk_clr), .upd(upd_best),
    .cand_id(cur_id), .cand_hops(cur_hops), .cand_q(cur_q),
    .id(bt_id), .hops(bt_hops), .q(bt_q));

  best_neighbor_select_nbr_tracker #(.WORD_WIDTH(WORD_WIDTH)) u_all_trk (
    .clock(clock), .rst(rst), .clr(trk_clr), .upd(upd_all),
    .cand_id(cur_id), .cand_hops(cur_hops), .cand_q(cur_q),
    .id(at_id), .hops(at_hops), .q(at_q));

  // Scan sequencer; memory port and results are registered on state entry.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.wr_en      <= 1'b0;
      bus.address    <= '0;
      bus.data_out   <= '0;
      eff_cnt        <= '0;
      n_idx          <= '0;
      cur_id         <= '0;
      cur_hops       <= '0;
      cur_q          <= '0;
      close_flag     <= 1'b0;
      besthop        <= '0;
      bestneighborID <= '0;
      bestQValue     <= '0;
      best_count     <= '0;
      close_count    <= '0;
      route_class    <= RC_NONE;
      overflow       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (en) begin
          besthop        <= '0;
          bestneighborID <= '0;
          bestQValue     <= '0;
          best_count     <= '0;
          close_count    <= '0;
          route_class    <= RC_NONE;
          overflow       <= 1'b0;
          busy           <= 1'b1;
          state          <= S_ARMED;
        end
        S_ARMED: if (start) begin
          bus.address <= NCOUNT_ADDR;
          state       <= S_CNT_W;
        end
        S_CNT_W: state <= S_CNT_C;
        S_CNT_C: begin
          overflow <= bus.data_in > WORD_WIDTH'(MAX_NEIGHBORS);
          eff_cnt  <= (bus.data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ?
                      WORD_WIDTH'(MAX_NEIGHBORS) : bus.data_in;
          n_idx    <= '0;
          if (bus.data_in == '0) begin
            bus.wr_en    <= 1'b1;
            bus.address  <= BCOUNT_ADDR;
            bus.data_out <= best_count;
            state        <= S_WR_BC;
          end else begin
            bus.address <= addr_of(NID_BASE, '0);
            state       <= S_ID_I;
          end
        end
        S_ID_I: state <= S_ID_C;
        S_ID_C: begin
          cur_id      <= bus.data_in;
          bus.address <= addr_of(NHOPS_BASE, n_idx);
          state       <= S_HOP_I;
        end
        S_HOP_I: state <= S_HOP_C;
        S_HOP_C: begin
          cur_hops    <= bus.data_in;
          bus.address <= addr_of(NQ_BASE, n_idx);
          state       <= S_Q_I;
        end
        S_Q_I: state <= S_Q_C;
        S_Q_C: begin
          cur_q <= bus.data_in;
          state <= S_EVAL;
        end
        S_EVAL: begin
          close_flag <= is_close;
          if (is_best) begin
            bus.wr_en    <= 1'b1;
            bus.address  <= addr_of(BEST_BASE, best_count);
            bus.data_out <= cur_id;
            state        <= S_WB_ID;
          end else if (is_close) begin
            bus.wr_en    <= 1'b1;
            bus.address  <= addr_of(CLOSE_BASE, close_count);
            bus.data_out <= cur_id;
            state        <= S_WC_ID;
          end else begin
            state <= S_NEXT;
          end
        end
        S_WB_ID: begin
          bus.address  <= addr_of(BESTH_BASE, best_count);
          bus.data_out <= cur_hops;
          state        <= S_WB_H;
        end
        S_WB_H: begin
          best_count <= best_count + WORD_WIDTH'(1);
          if (close_flag) begin
            bus.address  <= addr_of(CLOSE_BASE, close_count);
            bus.data_out <= cur_id;
            state        <= S_WC_ID;
          end else begin
            bus.wr_en <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_WC_ID: begin
          bus.address  <= addr_of(CLOSEH_BASE, close_count);
          bus.data_out <= cur_hops;
          state        <= S_WC_H;
        end
        S_WC_H: begin
          close_count <= close_count + WORD_WIDTH'(1);
          bus.wr_en   <= 1'b0;
          state       <= S_NEXT;
        end
        S_NEXT: begin
          n_idx <= n_next;
          if (n_next == eff_cnt) begin
            bus.wr_en    <= 1'b1;
            bus.address  <= BCOUNT_ADDR;
            bus.data_out <= best_count;
            state        <= S_WR_BC;
          end else begin
            bus.address <= addr_of(NID_BASE, n_next);
            state       <= S_ID_I;
          end
        end
        S_WR_BC: begin
          bus.address  <= CCOUNT_ADDR;
          bus.data_out <= close_count;
          state        <= S_WR_CC;
        end
        S_WR_CC: begin
          bus.wr_en <= 1'b0;
          done      <= 1'b1;
          if (best_count != '0) begin
            bestneighborID <= bt_id;
            besthop        <= bt_hops;
            bestQValue     <= bt_q;
            route_class    <= RC_BEST;
          end else if (close_count != '0) begin
            bestneighborID <= at_id;
            besthop        <= at_hops;
            bestQValue     <= at_q;
            route_class    <= RC_CLOSE;
          end else if (eff_cnt != '0) begin
            bestneighborID <= at_id;
            besthop        <= at_hops;
            bestQValue     <= at_q;
            route_class    <= RC_FALLBACK;
          end else begin
            route_class <= RC_NONE;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_best_neighbor_select.sv
// Bench for best_neighbor_select: synchronous-read memory model, directed
// table scenarios, randomized tables, and a reset during a write.
module tb_best_neighbor_select;
  localparam logic [10:0] A_NCOUNT = 11'h2C4, A_NID = 11'h072, A_NHOPS = 11'h132;
  localparam logic [10:0] A_NQ = 11'h172, A_BEST = 11'h2F8, A_BESTH = 11'h308;
  localparam logic [10:0] A_CLOSE = 11'h318, A_CLOSEH = 11'h328;
  localparam logic [10:0] A_BCOUNT = 11'h2B8, A_CCOUNT = 11'h338;
  localparam int MAXN = 8;

  logic clock = 1'b0;
  logic rst, en, start;
  logic [15:0] mybestQ, mybestH;
  logic [15:0] besthop, bestneighborID, bestQValue, best_count, close_count;
  logic [1:0]  route_class;
  logic        overflow, busy, done;

  best_neighbor_select_if bus ();

  best_neighbor_select dut (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .mybestQ(mybestQ), .mybestH(mybestH), .bus(bus),
    .besthop(besthop), .bestneighborID(bestneighborID), .bestQValue(bestQValue),
    .best_count(best_count), .close_count(close_count), .route_class(route_class),
    .overflow(overflow), .busy(busy), .done(done));

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];
  logic [15:0] rd;
  logic        host_we = 1'b0;
  logic [10:0] host_addr = '0;
  logic [15:0] host_data = '0;
  logic [10:0] prev_addr = '0;
  int          wr_count = 0;
  int          id_reads = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] t_id [16];
  logic [15:0] t_hops [16];
  logic [15:0] t_q [16];

  assign bus.data_in = rd;

  always @(posedge clock) begin
    rd <= mem[bus.address];
    if (bus.wr_en) begin
      mem[bus.address] <= bus.data_out;
      wr_count <= wr_count + 1;
    end else if (host_we) begin
      mem[host_addr] <= host_data;
    end
    prev_addr <= bus.address;
    if (bus.address != prev_addr && bus.address >= A_NID && bus.address < A_NID + 11'd32)
      id_reads <= id_reads + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(posedge clock); #1;
    host_we = 1'b0;
  endtask

  task automatic load(input int cnt);
    host_wr(A_NCOUNT, 16'(cnt));
    for (int i = 0; i < 16; i++) begin
      host_wr(11'(A_NID + 2*i), t_id[i]);
      host_wr(11'(A_NHOPS + 2*i), t_hops[i]);
      host_wr(11'(A_NQ + 2*i), t_q[i]);
    end
    for (int k = 0; k < MAXN; k++) begin
      host_wr(11'(A_BEST + 2*k), 16'hDEAD);
      host_wr(11'(A_BESTH + 2*k), 16'hDEAD);
      host_wr(11'(A_CLOSE + 2*k), 16'hDEAD);
      host_wr(11'(A_CLOSEH + 2*k), 16'hDEAD);
    end
    host_wr(A_BCOUNT, 16'hDEAD);
    host_wr(A_CCOUNT, 16'hDEAD);
  endtask

  task automatic launch();
    en = 1'b1;
    @(posedge clock); #1;
    en = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input int cnt, input logic [15:0] qth, input logic [15:0] hth,
                          input string tag);
    int eff, exp_cyc, cyc, w0, r0, minh, maxq, sel;
    int bidx[$], cidx[$], cand[$];
    logic [1:0] exp_rc;
    mybestQ = qth; mybestH = hth;
    load(cnt);
    w0 = wr_count; r0 = id_reads;
    launch();
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
      if (done) break;
    end
    // Reference: lists, timing and selection straight from the table.
    eff = (cnt > MAXN) ? MAXN : cnt;
    exp_cyc = 4;
    for (int i = 0; i < eff; i++) begin
      if (t_q[i] >= qth) bidx.push_back(i);
      if (t_hops[i] <= hth) cidx.push_back(i);
      exp_cyc += 8 + ((t_q[i] >= qth) ? 2 : 0) + ((t_hops[i] <= hth) ? 2 : 0);
    end
    if (bidx.size() > 0) begin cand = bidx; exp_rc = 2'd1; end
    else begin
      for (int i = 0; i < eff; i++) cand.push_back(i);
      exp_rc = (cidx.size() > 0) ? 2'd2 : ((eff > 0) ? 2'd3 : 2'd0);
    end
    sel = -1;
    if (cand.size() > 0) begin
      minh = 32'hFFFF; maxq = -1;
      foreach (cand[k]) if (int'(t_hops[cand[k]]) < minh) minh = t_hops[cand[k]];
      foreach (cand[k]) if (int'(t_hops[cand[k]]) == minh && int'(t_q[cand[k]]) > maxq) maxq = t_q[cand[k]];
      foreach (cand[k]) if (sel < 0 && int'(t_hops[cand[k]]) == minh && int'(t_q[cand[k]]) == maxq) sel = cand[k];
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_class"}, route_class, exp_rc);
    chk({tag, "_id"}, bestneighborID, (sel < 0) ? 0 : t_id[sel]);
    chk({tag, "_hop"}, besthop, (sel < 0) ? 0 : t_hops[sel]);
    chk({tag, "_q"}, bestQValue, (sel < 0) ? 0 : t_q[sel]);
    chk({tag, "_bcnt"}, best_count, bidx.size());
    chk({tag, "_ccnt"}, close_count, cidx.size());
    chk({tag, "_ovf"}, overflow, cnt > MAXN);
    chk({tag, "_wren_lo"}, bus.wr_en, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_writes"}, wr_count - w0, 2*bidx.size() + 2*cidx.size() + 2);
    chk({tag, "_reads"}, id_reads - r0, eff);
    chk({tag, "_mem_bc"}, mem[A_BCOUNT], bidx.size());
    chk({tag, "_mem_cc"}, mem[A_CCOUNT], cidx.size());
    foreach (bidx[k]) begin
      chk({tag, "_best_id"}, mem[11'(A_BEST + 2*k)], t_id[bidx[k]]);
      chk({tag, "_best_h"}, mem[11'(A_BESTH + 2*k)], t_hops[bidx[k]]);
    end
    foreach (cidx[k]) begin
      chk({tag, "_close_id"}, mem[11'(A_CLOSE + 2*k)], t_id[cidx[k]]);
      chk({tag, "_close_h"}, mem[11'(A_CLOSEH + 2*k)], t_hops[cidx[k]]);
    end
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_hold"}, bestneighborID, (sel < 0) ? 0 : t_id[sel]);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; en = 1'b0; start = 1'b0; mybestQ = '0; mybestH = '0;
    for (int i = 0; i < 16; i++) begin t_id[i] = 16'(i + 1); t_hops[i] = '0; t_q[i] = '0; end
    repeat (3) @(posedge clock);
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", route_class, 0);
    chk("rst_addr", bus.address, 0);
    rst = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    chk("start_ignored_idle", busy, 0);

    run_scan(0, 16'd0, 16'd0, "cnt0");

    t_id[0] = 16'd5;  t_hops[0] = 16'd3; t_q[0] = 16'd10;
    t_id[1] = 16'd6;  t_hops[1] = 16'd1; t_q[1] = 16'd40;
    t_id[2] = 16'd7;  t_hops[2] = 16'd2; t_q[2] = 16'd40;
    run_scan(3, 16'd40, 16'd1, "three_best");
    run_scan(3, 16'd50, 16'd2, "three_close");
    run_scan(3, 16'd50, 16'd0, "three_fallback");

    t_id[0] = 16'd9; t_hops[0] = 16'd2; t_q[0] = 16'd30;
    t_id[1] = 16'd4; t_hops[1] = 16'd2; t_q[1] = 16'd30;
    run_scan(2, 16'd30, 16'd0, "tie");

    for (int i = 0; i < 16; i++) begin
      t_id[i] = 16'($urandom_range(1, 16'hFFFF));
      t_hops[i] = 16'($urandom_range(0, 4));
      t_q[i] = 16'($urandom_range(0, 5));
    end
    run_scan(12, 16'd3, 16'd1, "overflow");

    // Reset arriving while a write is on the bus.
    mybestQ = 16'd0; mybestH = 16'd0;
    load(12);
    launch();
    cyc = 0;
    while (cyc < 300 && !bus.wr_en) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("rst_mid_wr_seen", bus.wr_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wr_en", bus.wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovf", overflow, 0);
    #3 rst = 1'b0;
    run_scan(12, 16'd2, 16'd2, "after_rst");

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) begin
        t_id[i] = 16'($urandom_range(1, 16'hFFFF));
        t_hops[i] = 16'($urandom_range(0, 4));
        t_q[i] = 16'($urandom_range(0, 5));
      end
      run_scan(int'($urandom_range(0, 11)), 16'($urandom_range(0, 6)),
               16'($urandom_range(0, 4)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
